// File: rtl/lsu_ram_ctrl_pkg.sv
// Shared types and constants for the load/store RAM controller:
// access-size encodings, FSM state encodings and small decode helpers.
package lsu_ram_ctrl_pkg;

    localparam logic [1:0] SL_BYTE = 2'b00;
    localparam logic [1:0] SL_HALF = 2'b01;
    localparam logic [1:0] SL_WORD = 2'b10;

    typedef enum logic [2:0] {
        LSU_IDLE = 3'd0,
        LSU_RD0  = 3'd1,
        LSU_RD1  = 3'd2,
        LSU_WR0  = 3'd3,
        LSU_WR1  = 3'd4,
        LSU_DONE = 3'd5
    } lsu_state_e;

    // Unknown size codes fall back to a full word.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] bhw);
        case (bhw)
            SL_BYTE: return 3'd1;
            SL_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic access_spans(input logic [1:0] off, input logic [2:0] nbytes);
        return ({1'b0, off} + nbytes) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension
// across a two-word window, and store merge of the data into buf0/buf1.
module lsu_align
    import lsu_ram_ctrl_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  nbytes_i,
    input  logic        unsigned_i,
    input  logic [31:0] lo_word_i,
    input  logic [31:0] hi_word_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] buf0_i,
    input  logic [31:0] buf1_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge0_o,
    output logic [31:0] merge1_o
);

    logic [63:0] pair_sh;
    logic [63:0] wdata_sh;
    logic [63:0] merged;
    logic [7:0]  base_mask;
    logic [7:0]  lane_mask;

    assign pair_sh  = {hi_word_i, lo_word_i} >> {off_i, 3'b000};
    assign wdata_sh = {32'b0, wdata_i} << {off_i, 3'b000};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_data_o = pair_sh[31:0];
        case (nbytes_i)
            3'd1:    load_data_o = {{24{~unsigned_i & pair_sh[7]}},  pair_sh[7:0]};
            3'd2:    load_data_o = {{16{~unsigned_i & pair_sh[15]}}, pair_sh[15:0]};
            default: load_data_o = pair_sh[31:0];
        endcase
    end

    // Lanes 0-3 belong to buf0 (word w0), lanes 4-7 to buf1 (word w1).
    always_comb begin
        case (nbytes_i)
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
        lane_mask = base_mask << off_i;
        merged    = {buf1_i, buf0_i};
        for (int b = 0; b < 8; b++) begin
            if (lane_mask[b]) begin
                merged[8*b +: 8] = wdata_sh[8*b +: 8];
            end
        end
    end

    assign merge0_o = merged[31:0];
    assign merge1_o = merged[63:32];

endmodule

// File: rtl/lsu_ram_ctrl.sv
// Load/store controller between the core memory stage and a 64-word RAM:
// sub-word, signed/unsigned and word-boundary-crossing accesses via read-modify-write.
module lsu_ram_ctrl
    import lsu_ram_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [1:0]  req_bhw,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    output logic [1:0]  ram_bhw,
    input  logic [31:0] ram_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [2:0]  nbytes_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] buf0_q;
    logic [31:0] buf1_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic [1:0]  off;
    logic [5:0]  w0;
    logic [5:0]  w1;
    logic        span;
    logic [2:0]  req_nbytes;
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic [31:0] load_data;
    logic [31:0] merge0;
    logic [31:0] merge1;

    assign accept     = req_valid & (state_q == LSU_IDLE);
    assign req_nbytes = size_to_nbytes(req_bhw);
    assign off        = addr_q[1:0];
    assign w0         = addr_q[7:2];
    assign w1         = w0 + 6'd1;
    assign span       = access_spans(off, nbytes_q);

    // The word being read this cycle is taken straight from the RAM so the
    // extracted result can be registered on the edge that leaves the read state.
    assign lo_word = (state_q == LSU_RD0) ? ram_rdata : buf0_q;
    assign hi_word = (state_q == LSU_RD1) ? ram_rdata : buf1_q;

    lsu_align u_align (
        .off_i       (off),
        .nbytes_i    (nbytes_q),
        .unsigned_i  (uns_q),
        .lo_word_i   (lo_word),
        .hi_word_i   (hi_word),
        .wdata_i     (wdata_q),
        .buf0_i      (buf0_q),
        .buf1_i      (buf1_q),
        .load_data_o (load_data),
        .merge0_o    (merge0),
        .merge1_o    (merge1)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    if (req_we && req_nbytes == 3'd4 && req_addr[1:0] == 2'b00) begin
                        state_d = LSU_WR0;
                    end else begin
                        state_d = LSU_RD0;
                    end
                end
            end
            LSU_RD0:  state_d = span ? LSU_RD1 : (we_q ? LSU_WR0 : LSU_DONE);
            LSU_RD1:  state_d = we_q ? LSU_WR0 : LSU_DONE;
            LSU_WR0:  state_d = span ? LSU_WR1 : LSU_DONE;
            LSU_WR1:  state_d = LSU_DONE;
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == LSU_IDLE);
        rsp_valid = (state_q == LSU_DONE);
        ram_cs    = (state_q == LSU_RD0) || (state_q == LSU_RD1) ||
                    (state_q == LSU_WR0) || (state_q == LSU_WR1);
        ram_we    = (state_q == LSU_WR0) || (state_q == LSU_WR1);
        ram_addr  = {w0, 2'b00};
        ram_wdata = merge0;
        if (state_q == LSU_RD1 || state_q == LSU_WR1) begin
            ram_addr  = {w1, 2'b00};
            ram_wdata = merge1;
        end
    end

    assign ram_bhw   = SL_WORD;
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            addr_q   <= 8'd0;
            nbytes_q <= 3'd0;
            uns_q    <= 1'b0;
            wdata_q  <= 32'd0;
            buf0_q   <= 32'd0;
            buf1_q   <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (accept) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr;
                        nbytes_q <= req_nbytes;
                        uns_q    <= req_unsigned;
                        wdata_q  <= req_wdata;
                        rdata_q  <= 32'd0;
                    end
                end
                LSU_RD0: begin
                    buf0_q <= ram_rdata;
                    if (!we_q && !span) begin
                        rdata_q <= load_data;
                    end
                end
                LSU_RD1: begin
                    buf1_q <= ram_rdata;
                    if (!we_q) begin
                        rdata_q <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Directed bench for lsu_ram_ctrl: vector table of single requests against a
// behavioural RAM, plus hand sequences for wrap addressing, reset in WR1 and back-to-back.
module tb_lsu_ram_ctrl;
    import lsu_ram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = 8'd0;
    logic [1:0]  req_bhw = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        ram_cs;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [1:0]  ram_bhw;
    logic [31:0] ram_rdata;

    logic [31:0] mem [64];
    logic        mem_init = 1'b0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_viol = 0;
    logic [7:0]  addr_log [$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_ram_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_bhw      (req_bhw),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_bhw      (ram_bhw),
        .ram_rdata    (ram_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'hAAFF72CC;
        if (i == 1) return 32'h00000001;
        return 32'(10 * i);
    endfunction

    assign ram_rdata = mem[ram_addr[7:2]];

    // Behavioural RAM: power-up contents on mem_init, word writes on the clock.
    always @(posedge clk or posedge mem_init) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        end else if (ram_cs) begin
            if (ram_addr[1:0] != 2'b00) n_viol++;
            if (ram_we) begin
                mem[ram_addr[7:2]] <= ram_wdata;
                n_wr++;
            end else begin
                n_rd++;
            end
            addr_log.push_back(ram_addr);
        end else if (ram_we) begin
            n_viol++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reload_ram();
        @(negedge clk);
        mem_init = 1'b1;
        #1;
        mem_init = 1'b0;
    endtask

    // Issues one request and measures latency in edges counted from the edge that
    // starts the handshake cycle (E0), so rsp_valid after E2 gives lat = 2.
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [1:0] bhw,
                          input logic uns, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic clean);
        int cyc;
        clean = 1'b1;
        @(negedge clk);
        req_we = we; req_addr = addr; req_bhw = bhw;
        req_unsigned = uns; req_wdata = wdata; req_valid = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (req_ready) clean = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (req_ready) clean = 1'b0;
        rdata = rsp_rdata;
        @(negedge clk);
        if (rsp_valid || !req_ready) clean = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [7:0]  addr;
        logic [1:0]  bhw;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        int          ia;
        logic [31:0] wa;
        int          ib;
        logic [31:0] wb;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int          lat;
        logic [31:0] rdata;
        logic        clean;
        int          rd0, wr0, log0, other, cyc;
        logic        ready_ok;

        vecs[0]  = '{"lb_00",    1'b0, 8'h00, SL_BYTE, 1'b0, 32'h0, 32'hFFFFFFCC, 2, 1, 0, -1, 32'h0, -1, 32'h0};
        vecs[1]  = '{"lbu_03",   1'b0, 8'h03, SL_BYTE, 1'b1, 32'h0, 32'h000000AA, 2, 1, 0, -1, 32'h0, -1, 32'h0};
        vecs[2]  = '{"lh_01",    1'b0, 8'h01, SL_HALF, 1'b0, 32'h0, 32'hFFFFFF72, 2, 1, 0, -1, 32'h0, -1, 32'h0};
        vecs[3]  = '{"lw_02",    1'b0, 8'h02, SL_WORD, 1'b0, 32'h0, 32'h0001AAFF, 3, 2, 0, -1, 32'h0, -1, 32'h0};
        vecs[4]  = '{"lh_03",    1'b0, 8'h03, SL_HALF, 1'b0, 32'h0, 32'h000001AA, 3, 2, 0, -1, 32'h0, -1, 32'h0};
        vecs[5]  = '{"lh_ff",    1'b0, 8'hFF, SL_HALF, 1'b0, 32'h0, 32'hFFFFCC00, 3, 2, 0, -1, 32'h0, -1, 32'h0};
        vecs[6]  = '{"lhu_00",   1'b0, 8'h00, SL_HALF, 1'b1, 32'h0, 32'h000072CC, 2, 1, 0, -1, 32'h0, -1, 32'h0};
        vecs[7]  = '{"lw_bhw3",  1'b0, 8'h04, 2'b11,   1'b1, 32'h0, 32'h00000001, 2, 1, 0, -1, 32'h0, -1, 32'h0};
        vecs[8]  = '{"lb_02",    1'b0, 8'h02, SL_BYTE, 1'b0, 32'h0, 32'hFFFFFFFF, 2, 1, 0, -1, 32'h0, -1, 32'h0};
        vecs[9]  = '{"sb_09",    1'b1, 8'h09, SL_BYTE, 1'b0, 32'h12345678, 32'h0, 3, 1, 1, 2, 32'h00007814, -1, 32'h0};
        vecs[10] = '{"sw_10",    1'b1, 8'h10, SL_WORD, 1'b0, 32'hCAFEF00D, 32'h0, 2, 0, 1, 4, 32'hCAFEF00D, -1, 32'h0};
        vecs[11] = '{"sh_06",    1'b1, 8'h06, SL_HALF, 1'b0, 32'hABCD1234, 32'h0, 3, 1, 1, 1, 32'h12340001, -1, 32'h0};
        vecs[12] = '{"sw_fe",    1'b1, 8'hFE, SL_WORD, 1'b0, 32'hDEADBEEF, 32'h0, 5, 2, 2, 63, 32'hBEEF0276, 0, 32'hAAFFDEAD};
        vecs[13] = '{"sb_ff",    1'b1, 8'hFF, SL_BYTE, 1'b1, 32'h0000009A, 32'h0, 3, 1, 1, 63, 32'h9A000276, -1, 32'h0};
        vecs[14] = '{"sh_0b",    1'b1, 8'h0B, SL_HALF, 1'b0, 32'h00005566, 32'h0, 5, 2, 2, 2, 32'h66000014, 3, 32'h00000055};

        // Reset state
        reload_ram();
        #1;
        check("reset_ready", {31'b0, req_ready}, 32'd1);
        check("reset_rsp", {31'b0, rsp_valid}, 32'd0);
        check("reset_cs_we", {30'b0, ram_cs, ram_we}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 15; v++) begin
            reload_ram();
            rd0 = n_rd;
            wr0 = n_wr;
            do_req(vecs[v].we, vecs[v].addr, vecs[v].bhw, vecs[v].uns, vecs[v].wdata, lat, rdata, clean);
            check({vecs[v].name, "_rdata"}, rdata, vecs[v].exp_rdata);
            check({vecs[v].name, "_lat"}, 32'(lat), 32'(vecs[v].exp_lat));
            check({vecs[v].name, "_reads"}, 32'(n_rd - rd0), 32'(vecs[v].exp_rd));
            check({vecs[v].name, "_writes"}, 32'(n_wr - wr0), 32'(vecs[v].exp_wr));
            check({vecs[v].name, "_handshake"}, {31'b0, clean}, 32'd1);
            other = 0;
            for (int i = 0; i < 64; i++) begin
                if (i == vecs[v].ia) check({vecs[v].name, "_word_a"}, mem[i], vecs[v].wa);
                else if (i == vecs[v].ib) check({vecs[v].name, "_word_b"}, mem[i], vecs[v].wb);
                else if (mem[i] !== init_word(i)) other++;
            end
            check({vecs[v].name, "_untouched"}, 32'(other), 32'd0);
        end

        // Wrapping word store: RAM address order FC, 00, FC, 00
        reload_ram();
        log0 = addr_log.size();
        do_req(1'b1, 8'hFE, SL_WORD, 1'b0, 32'hDEADBEEF, lat, rdata, clean);
        check("wrap_log_len", 32'(addr_log.size() - log0), 32'd4);
        if (addr_log.size() >= log0 + 4) begin
            check("wrap_addr0", {24'b0, addr_log[log0]},   32'h000000FC);
            check("wrap_addr1", {24'b0, addr_log[log0+1]}, 32'h00000000);
            check("wrap_addr2", {24'b0, addr_log[log0+2]}, 32'h000000FC);
            check("wrap_addr3", {24'b0, addr_log[log0+3]}, 32'h00000000);
        end

        // Reset asserted in WR1 of the wrapping store
        reload_ram();
        @(negedge clk);
        req_we = 1'b1; req_addr = 8'hFE; req_bhw = SL_WORD; req_unsigned = 1'b0;
        req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!(ram_we && ram_addr == 8'h00) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_wr1_reached", {31'b0, ram_we && ram_addr == 8'h00}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_cs_we_drop", {30'b0, ram_cs, ram_we}, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        clean = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) clean = 1'b0;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) clean = 1'b0;
        end
        check("rst_no_rsp", {31'b0, clean}, 32'd1);
        check("rst_word63", mem[63], 32'hBEEF0276);
        check("rst_word0", mem[0], 32'hAAFF72CC);

        // Back-to-back with req_valid held high
        reload_ram();
        @(negedge clk);
        req_we = 1'b0; req_addr = 8'h00; req_bhw = SL_BYTE; req_unsigned = 1'b0;
        req_wdata = 32'h0; req_valid = 1'b1;
        @(posedge clk);
        ready_ok = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!rsp_valid && cyc < 20) begin
            if (req_ready) ready_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (req_ready) ready_ok = 1'b0;
        check("b2b_busy_ready_low", {31'b0, ready_ok}, 32'd1);
        check("b2b_first_rdata", rsp_rdata, 32'hFFFFFFCC);
        req_we = 1'b1; req_addr = 8'h20; req_bhw = SL_WORD; req_wdata = 32'h11223344;
        rd0 = n_rd;
        wr0 = n_wr;
        @(negedge clk);
        check("b2b_ready_after_rsp", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_second_accepted", {31'b0, req_ready}, 32'd0);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_second_rsp", {31'b0, rsp_valid}, 32'd1);
        check("b2b_store_reads", 32'(n_rd - rd0), 32'd0);
        check("b2b_store_writes", 32'(n_wr - wr0), 32'd1);
        check("b2b_word8", mem[8], 32'h11223344);

        @(negedge clk);
        check("ram_bhw_word", {30'b0, ram_bhw}, {30'b0, SL_WORD});
        check("ram_discipline", 32'(n_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
